// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV32 pipeline.
//   Takes the EX/MEM register outputs and performs word loads and stores on
//   a data-memory port that uses a ready handshake. It stalls upstream while
//   memory is busy and holds the MEM/WB register that feeds writeback.
//   Accesses that are misaligned, or that wait too long, are aborted.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   ctrl_mem[4:0]         {reg_write, wb_sel[1:0], mem_read, mem_write}
//   rd_mem, alu_result    destination index, effective address / ALU result
//   write_data1, pc4_mem  store data, PC+4 for link writeback
//   dmem_*                data-memory request/handshake port
//   stall                 freeze the upstream pipeline registers this cycle
//   ctrl_wb, rd_wb,
//   wb_data               MEM/WB pipeline register
//   bus_err, misalign_err one-cycle abort pulses
//
// state  | meaning
// S_IDLE | no access outstanding; a new request may complete in zero waits
// S_WAIT | request issued, waiting for dmem_ready; cnt counts waited cycles
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ctrl_mem,
  input  logic [31:0] rd_mem,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data1,
  input  logic [31:0] pc4_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [2:0]  ctrl_wb,
  output logic [31:0] rd_wb,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        mem_op;
  logic        aligned;
  logic        misalign;
  logic        timeout_hit;
  logic [31:0] wb_mux;

  assign mem_op   = ctrl_mem[1] | ctrl_mem[0];
  assign aligned  = (alu_result[1:0] == 2'b00);
  assign misalign = mem_op & ~aligned;

  // Both states may drive a request, so state does not gate dmem_req. The
  // reset term keeps the port quiet while reset is held, whatever upstream shows.
  assign dmem_req   = reset_n & mem_op & aligned;
  assign dmem_we    = ctrl_mem[0];
  assign dmem_addr  = alu_result;
  assign dmem_wdata = write_data1;

  assign timeout_hit = (state == S_WAIT) & (cnt == CNT_LAST) & ~dmem_ready;
  assign stall       = dmem_req & ~dmem_ready & ~timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 8'd0;
        end
      end
      S_WAIT: begin
        if (dmem_ready || timeout_hit) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    endcase
  end

  // wb_sel 11 is unused by the decoder and falls back to the ALU result.
  always_comb begin
    case (ctrl_mem[3:2])
      2'b01:   wb_mux = dmem_rdata;
      2'b10:   wb_mux = pc4_mem;
      default: wb_mux = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_wb      <= 3'b000;
      rd_wb        <= 32'd0;
      wb_data      <= 32'd0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      bus_err      <= timeout_hit;
      misalign_err <= misalign;
      if (stall) begin
        // Bubble: writeback sees no write. rd_wb and wb_data keep their last values.
        ctrl_wb <= 3'b000;
      end else if (timeout_hit || misalign) begin
        ctrl_wb <= 3'b000;
        rd_wb   <= rd_mem;
        wb_data <= 32'd0;
      end else begin
        ctrl_wb <= ctrl_mem[4:2];
        rd_wb   <= rd_mem;
        wb_data <= wb_mux;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [2:0]  ctrl_wb;
  logic [31:0] rd_wb, wb_data;
  logic        bus_err, misalign_err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
    .alu_result(alu_result), .write_data1(write_data1), .pc4_mem(pc4_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .wb_data(wb_data),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        req, we, stl;
    logic [2:0]  cwb;
    logic [31:0] rwb, dwb;
    logic        be, me;
  } exp_t;

  exp_t q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  // Drive one cycle of inputs and queue what the DUT must show: the
  // combinational port this cycle and the MEM/WB state after the next edge.
  task automatic step(input logic [4:0] c, input logic [31:0] rd, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [31:0] pc4, input logic rdy,
                      input logic [31:0] rdata, input logic e_req, input logic e_we,
                      input logic e_stl, input logic [2:0] e_cwb, input logic [31:0] e_rwb,
                      input logic [31:0] e_dwb, input logic e_be, input logic e_me);
    exp_t e;
    ctrl_mem = c; rd_mem = rd; alu_result = alu; write_data1 = wd; pc4_mem = pc4;
    dmem_ready = rdy; dmem_rdata = rdata;
    e.addr = alu; e.wdata = wd; e.req = e_req; e.we = e_we; e.stl = e_stl;
    e.cwb = e_cwb; e.rwb = e_rwb; e.dwb = e_dwb; e.be = e_be; e.me = e_me;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: pops one expectation per cycle the stimulus issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dmem_req", 32'(dmem_req), 32'(e.req));
        chk("stall", 32'(stall), 32'(e.stl));
        chk("dmem_addr", dmem_addr, e.addr);
        if (e.req) begin
          chk("dmem_we", 32'(dmem_we), 32'(e.we));
          chk("dmem_wdata", dmem_wdata, e.wdata);
        end
        @(posedge clk); #2;
        chk("ctrl_wb", 32'(ctrl_wb), 32'(e.cwb));
        chk("rd_wb", rd_wb, e.rwb);
        chk("wb_data", wb_data, e.dwb);
        chk("bus_err", 32'(bus_err), 32'(e.be));
        chk("misalign_err", 32'(misalign_err), 32'(e.me));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ctrl_mem = 5'b10110; rd_mem = 32'd1; alu_result = 32'h200; write_data1 = 32'd0;
    pc4_mem = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    #3;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ctrl_wb", 32'(ctrl_wb), 32'd0);
    chk("rst_rd_wb", rd_wb, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_errs", 32'({bus_err, misalign_err}), 32'd0);
    @(negedge clk);
    ctrl_mem = 5'b00000; reset_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait store
    step(5'b00001, 5, 32'h100, 32'hDEADBEEF, 32'h104, 1, JUNK, 1, 1, 0, 3'b000, 5, 32'h100, 0, 0);
    // load with two wait states
    step(5'b10110, 7, 32'h200, 32'h0, 32'h204, 0, JUNK, 1, 0, 1, 3'b000, 5, 32'h100, 0, 0);
    step(5'b10110, 7, 32'h200, 32'h0, 32'h204, 0, JUNK, 1, 0, 1, 3'b000, 5, 32'h100, 0, 0);
    step(5'b10110, 7, 32'h200, 32'h0, 32'h204, 1, 32'h12345678, 1, 0, 0, 3'b101, 7, 32'h12345678, 0, 0);
    // timeout: stall for 4 cycles, abort on the 5th
    for (int i = 0; i < 4; i++)
      step(5'b10110, 9, 32'h300, 32'h0, 32'h304, 0, JUNK, 1, 0, 1, 3'b000, 7, 32'h12345678, 0, 0);
    step(5'b10110, 9, 32'h300, 32'h0, 32'h304, 0, JUNK, 1, 0, 0, 3'b000, 9, 32'h0, 1, 0);
    // ready with no request is ignored
    step(5'b00000, 1, 32'h11, 32'h0, 32'h0, 1, JUNK, 0, 0, 0, 3'b000, 1, 32'h11, 0, 0);
    // misaligned store, then misaligned load
    step(5'b00001, 3, 32'h102, 32'hCAFEF00D, 32'h0, 1, JUNK, 0, 1, 0, 3'b000, 3, 32'h0, 0, 1);
    step(5'b00000, 2, 32'h22, 32'h0, 32'h0, 0, JUNK, 0, 0, 0, 3'b000, 2, 32'h22, 0, 0);
    step(5'b10110, 4, 32'h201, 32'h0, 32'h0, 0, JUNK, 0, 0, 0, 3'b000, 4, 32'h0, 0, 1);
    step(5'b00000, 6, 32'h66, 32'h0, 32'h0, 0, JUNK, 0, 0, 0, 3'b000, 6, 32'h66, 0, 0);
    // link, ALU passthrough, wb_sel 11, read+write counts as store
    step(5'b11000, 1, 32'h999, 32'h0, 32'h44, 0, JUNK, 0, 0, 0, 3'b110, 1, 32'h44, 0, 0);
    step(5'b10000, 2, 32'h7, 32'h0, 32'h0, 0, JUNK, 0, 0, 0, 3'b100, 2, 32'h7, 0, 0);
    step(5'b11100, 8, 32'h55, 32'h0, 32'h66, 0, JUNK, 0, 0, 0, 3'b111, 8, 32'h55, 0, 0);
    step(5'b00011, 10, 32'h104, 32'h5A5A, 32'h0, 1, JUNK, 1, 1, 0, 3'b000, 10, 32'h104, 0, 0);
    drain();

    // reset in the middle of a load wait
    ctrl_mem = 5'b10110; rd_mem = 32'd12; alu_result = 32'h400; dmem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_ctrl_wb", 32'(ctrl_wb), 32'd0);
    chk("mid_rst_rd_wb", rd_wb, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    ctrl_mem = 5'b00000; rd_mem = 32'd0; alu_result = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    step(5'b00000, 0, 32'h0, 32'h0, 32'h0, 0, JUNK, 0, 0, 0, 3'b000, 0, 32'h0, 0, 0);
    // a fresh load must get the full wait budget
    for (int i = 0; i < 4; i++)
      step(5'b10110, 13, 32'h500, 32'h0, 32'h0, 0, JUNK, 1, 0, 1, 3'b000, 0, 32'h0, 0, 0);
    step(5'b10110, 13, 32'h500, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 1, 0, 0, 3'b101, 13, 32'hA5A5A5A5, 0, 0);
    step(5'b00000, 0, 32'h0, 32'h0, 32'h0, 0, JUNK, 0, 0, 0, 3'b000, 0, 32'h0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline, directly downstream of EX.
- Consumes the EX/MEM register outputs and performs word loads/stores on a data-memory port with a ready handshake.
- Stalls upstream while memory is busy and holds the MEM/WB pipeline register that feeds writeback.
- Aborts accesses that are misaligned or exceed a timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT without dmem_ready before abort. Legal range 2..255; counter is 8 bits.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ctrl_mem  in  5  [4] reg_write, [3:2] wb_sel (00 alu, 01 load, 10 pc4, 11 alu), [1] mem_read, [0] mem_write
rd_mem  in  32  destination register index, passed through
alu_result  in  32  effective address / ALU result
write_data1  in  32  store data
pc4_mem  in  32  PC+4 for link writeback
dmem_req  out  1  memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  byte address, always alu_result
dmem_wdata  out  32  always write_data1
dmem_ready  in  1  access completes this cycle
dmem_rdata  in  32  load data, valid when dmem_ready=1
stall  out  1  freeze PC/IF/ID/EX registers this cycle
ctrl_wb  out  3  registered {reg_write, wb_sel}
rd_wb  out  32  registered destination index
wb_data  out  32  registered writeback value
bus_err  out  1  registered one-cycle pulse on timeout abort
misalign_err  out  1  registered one-cycle pulse on misaligned access

Behaviour:
- mem_op = ctrl_mem[1] | ctrl_mem[0]. If both bits are set, the access is a store.
- aligned = (alu_result[1:0] == 0). Word accesses only.
- FSM states: IDLE and WAIT. An 8-bit counter cnt runs in WAIT.
- dmem_req = reset_n & mem_op & aligned & (state==IDLE or state==WAIT). dmem_req is combinational.
- dmem_we = ctrl_mem[0].
- timeout_hit = (state==WAIT) & (cnt == TIMEOUT_CYCLES-1) & ~dmem_ready.
- stall = dmem_req & ~dmem_ready & ~timeout_hit. Zero-wait accesses never stall.
- Upstream keeps its inputs stable while stall=1. The address and store data must not change during WAIT.
- IDLE transitions:
  - dmem_req & ~dmem_ready -> WAIT with cnt=0.
  - Otherwise remain in IDLE.
- WAIT transitions:
  - dmem_ready -> IDLE.
  - timeout_hit -> IDLE.
  - Otherwise cnt+1.
- MEM/WB register update, every clock edge:
  - If stall=1: insert bubble. ctrl_wb<=0; rd_wb and wb_data hold.
  - Else if timeout_hit or (mem_op & ~aligned): squash. ctrl_wb<=0, rd_wb<=rd_mem, wb_data<=0.
  - Else: ctrl_wb<=ctrl_mem[4:2], rd_wb<=rd_mem, and wb_data by wb_sel: 00/11 alu_result, 01 dmem_rdata, 10 pc4_mem.
- bus_err <= timeout_hit. misalign_err <= mem_op & ~aligned. Both are high for exactly one cycle.
- Misaligned access:
  - No request is issued and no stall is raised.
  - A misaligned store must not reach memory.
- Non-memory instructions pass to MEM/WB in one cycle with no request.
- Latency: MEM/WB outputs update on the edge that completes the access (dmem_ready high), or on the next edge for non-memory instructions.
- Reset (asynchronous, any state including WAIT):
  - state=IDLE, cnt=0.
  - ctrl_wb=0, rd_wb=0, wb_data=0, bus_err=0, misalign_err=0.
  - dmem_req=0 and stall=0 immediately while reset_n is low.
  - After release, a pending access is not resumed.
- dmem_ready while dmem_req=0 is ignored.

Test Plan:
1. Zero-wait store: ctrl_mem=5'b00001, alu_result=0x100, write_data1=0xDEADBEEF, dmem_ready=1 -> dmem_req=1, dmem_we=1 same cycle. stall=0. Next cycle ctrl_wb=0.
2. Load with 2 wait states: ctrl_mem=5'b10110, addr 0x200, ready on third cycle with rdata 0x12345678 -> stall=1 for 2 cycles, ctrl_wb=0 during the stall. Then ctrl_wb=3'b101, wb_data=0x12345678, rd_wb=rd_mem.
3. Timeout with TIMEOUT_CYCLES=4: load, dmem_ready never asserted -> stall high for 4 cycles then low. bus_err pulses once, ctrl_wb=0, FSM returns to IDLE.
4. Misaligned store: ctrl_mem=5'b00001, alu_result=0x102 -> dmem_req=0, stall=0. misalign_err=1 for one cycle.
5. JAL link and ALU passthrough: ctrl_mem=5'b11000, pc4_mem=0x44 -> next cycle wb_data=0x44, ctrl_wb=3'b110. Then ctrl_mem=5'b10000, alu_result=7 -> wb_data=7.
6. Reset mid-WAIT: assert reset_n=0 during a load wait -> dmem_req, stall, and all outputs go to 0 asynchronously. After release, the FSM is in IDLE and no bus_err is raised.
